// File: rtl/fe_receiver.sv
// fe_receiver: receiving end of the Fe bit-serial link.
//   Captures one-hot bit0/bit1 pulses inside a Dt-framed message. Each bit
//   gets a four-phase ack handshake. Once the whole message is in, the
//   assembled word is presented on data and senack acknowledges the frame.
//   Optional feature macro: FE_RX_PARITY_EN. When it is defined, each frame
//   carries one extra bit holding even parity over the data bits.
// Ports:
//   clk     in   1      system clock, rising edge
//   reset   in   1      asynchronous, active-high reset
//   Dt      in   1      frame active from sender
//   bit0    in   1      sender presents a 0 bit
//   bit1    in   1      sender presents a 1 bit
//   ack     out  1      per-bit acknowledge
//   senack  out  1      message-complete acknowledge
//   data    out  WIDTH  last good word, LSB = first bit received
//   err     out  1      protocol error flag for current/last frame
module fe_receiver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Dt,
    input  logic             bit0,
    input  logic             bit1,
    output logic             ack,
    output logic             senack,
    output logic [WIDTH-1:0] data,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef FE_RX_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BIT,
        S_ACK_HI,
        S_DONE,
        S_ERR
    } state_t;

    // Input synchronisers; the FSM only ever looks at the last stage
    logic [SYNC_STAGES-1:0] dt_sync_q, b0_sync_q, b1_sync_q;
    logic dt_s, b0_s, b1_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dt_sync_q <= '0;
            b0_sync_q <= '0;
            b1_sync_q <= '0;
        end else begin
            dt_sync_q <= {dt_sync_q[SYNC_STAGES-2:0], Dt};
            b0_sync_q <= {b0_sync_q[SYNC_STAGES-2:0], bit0};
            b1_sync_q <= {b1_sync_q[SYNC_STAGES-2:0], bit1};
        end
    end

    assign dt_s = dt_sync_q[SYNC_STAGES-1];
    assign b0_s = b0_sync_q[SYNC_STAGES-1];
    assign b1_s = b1_sync_q[SYNC_STAGES-1];

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;
    logic             senack_q, senack_d;
    logic             err_q, err_d;
`ifdef FE_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            ack_q        <= 1'b0;
            senack_q     <= 1'b0;
            err_q        <= 1'b0;
`ifdef FE_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            senack_q     <= senack_d;
            err_q        <= err_d;
`ifdef FE_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shreg_d      = shreg_q;
        data_d       = data_q;
        ack_d        = ack_q;
        senack_d     = senack_q;
        err_d        = err_q;
`ifdef FE_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dt_s) begin
                    state_d      = S_WAIT_BIT;
                    count_d      = '0;
                    shreg_d      = '0;
                    err_d        = 1'b0;
`ifdef FE_RX_PARITY_EN
                    parity_err_d = 1'b0;
`endif
                end
            end
            S_WAIT_BIT: begin
                if ((b0_s && b1_s) || !dt_s) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (b0_s ^ b1_s) begin
                    count_d = count_q + CW'(1);
                    ack_d   = 1'b1;
                    state_d = S_ACK_HI;
`ifdef FE_RX_PARITY_EN
                    // The bit after the data bits is parity: compare, never shift
                    if (count_q == CW'(WIDTH))
                        parity_err_d = (^shreg_q) ^ b1_s;
                    else
                        shreg_d = WIDTH'({b1_s, shreg_q} >> 1);
`else
                    shreg_d = WIDTH'({b1_s, shreg_q} >> 1);
`endif
                end
            end
            S_ACK_HI: begin
                if (!dt_s || (b0_s && b1_s)) begin
                    state_d = S_ERR;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (!b0_s && !b1_s) begin
                    ack_d = 1'b0;
                    if (count_q == LAST_CNT) begin
`ifdef FE_RX_PARITY_EN
                        if (parity_err_q) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d  = S_DONE;
                            data_d   = shreg_q;
                            senack_d = 1'b1;
                        end
`else
                        state_d  = S_DONE;
                        data_d   = shreg_q;
                        senack_d = 1'b1;
`endif
                    end else begin
                        state_d = S_WAIT_BIT;
                    end
                end
            end
            S_DONE: begin
                // Bit pulses are ignored here; only the frame end matters
                if (!dt_s) begin
                    senack_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_ERR: begin
                ack_d    = 1'b0;
                senack_d = 1'b0;
                err_d    = 1'b1;
                if (!dt_s)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack    = ack_q;
    assign senack = senack_q;
    assign data   = data_q;
    assign err    = err_q;

endmodule

// File: tb/tb_fe_receiver.sv
// tb_fe_receiver: randomized frame-level bench for fe_receiver.
//   Frames are built as bit queues; the expected word, parity outcome and
//   error behaviour are derived from the link rules at message level.
module tb_fe_receiver;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SYNC  = 2;
`ifdef FE_RX_PARITY_EN
    localparam int unsigned NB       = WIDTH + 1;
    localparam int          MAX_KIND = 3;
`else
    localparam int unsigned NB       = WIDTH;
    localparam int          MAX_KIND = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             Dt;
    logic             bit0;
    logic             bit1;
    logic             ack;
    logic             senack;
    logic             err;
    logic [WIDTH-1:0] data;

    int               checks = 0;
    int               errors = 0;
    int               ack_rises = 0;
    logic             ack_prev = 1'b0;
    logic [WIDTH-1:0] model_word = '0;

    fe_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .reset  (reset),
        .Dt     (Dt),
        .bit0   (bit0),
        .bit1   (bit1),
        .ack    (ack),
        .senack (senack),
        .data   (data),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Count ack pulses seen by the sender
    always @(negedge clk) begin
        if (ack === 1'b1 && ack_prev !== 1'b1)
            ack_rises++;
        ack_prev = ack;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int n = 0;
        while (ack !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ack), 32'(val));
    endtask

    // Four-phase handshake for one bit
    task automatic send_bit(input logic b);
        bit0 = ~b;
        bit1 = b;
        wait_ack(1'b1, "ack_rise");
        bit0 = 1'b0;
        bit1 = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    // kind: 0 good, 1 both bits high at bit pos, 2 Dt drops before bit pos, 3 bad parity
    task automatic run_frame(input logic [WIDTH-1:0] w, input int kind, input int pos);
        logic             q[$];
        int               ones;
        int               sent;
        bit               ok;
        logic [WIDTH-1:0] exp_word;
        ones = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            q.push_back(w[i]);
            ones += int'(w[i]);
        end
`ifdef FE_RX_PARITY_EN
        begin
            logic pb;
            pb = 1'(ones % 2);
            if (kind == 3)
                pb = ~pb;
            q.push_back(pb);
            ones += int'(pb);
        end
        ok = (kind == 0 || kind == 3) && (ones % 2 == 0);
`else
        ok = (kind == 0);
`endif
        exp_word = '0;
        for (int i = 0; i < int'(WIDTH); i++)
            if (q[i]) exp_word = exp_word | (WIDTH'(1) << i);

        ack_rises = 0;
        Dt = 1'b1;
        cycles(SYNC + 2);
        check("start_err_clear", 32'(err), 32'(0));
        sent = 0;
        for (int i = 0; i < int'(NB); i++) begin
            if (kind == 1 && i == pos) begin
                bit0 = 1'b1;
                bit1 = 1'b1;
                break;
            end
            if (kind == 2 && i == pos) begin
                Dt = 1'b0;
                break;
            end
            send_bit(q[i]);
            sent++;
        end

        if (ok) begin
            begin
                int n = 0;
                while (senack !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
            end
            check("senack_high", 32'(senack), 32'(1));
            check("data_word", 32'(data), 32'(exp_word));
            check("err_good", 32'(err), 32'(0));
            check("ack_pulses", 32'(ack_rises), 32'(NB));
            model_word = exp_word;
            // A stray bit while waiting for frame end must be ignored
            bit1 = 1'b1;
            cycles(SYNC + 3);
            bit1 = 1'b0;
            cycles(SYNC + 2);
            check("done_no_ack", 32'(ack_rises), 32'(NB));
            check("done_data", 32'(data), 32'(exp_word));
            Dt = 1'b0;
            cycles(SYNC + 1);
            check("senack_fall", 32'(senack), 32'(0));
            check("data_hold", 32'(data), 32'(model_word));
        end else begin
            cycles(SYNC + 4);
            check("err_set", 32'(err), 32'(1));
            check("senack_low", 32'(senack), 32'(0));
            check("ack_low", 32'(ack), 32'(0));
            check("err_acks", 32'(ack_rises), 32'(sent));
            check("err_data_keep", 32'(data), 32'(model_word));
            bit0 = 1'b0;
            bit1 = 1'b0;
            Dt   = 1'b0;
        end
        cycles(SYNC + 4);
        if (!ok)
            check("err_hold_idle", 32'(err), 32'(1));
    endtask

    initial begin
        reset = 1'b1;
        Dt    = 1'b0;
        bit0  = 1'b0;
        bit1  = 1'b0;
        cycles(3);
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_senack", 32'(senack), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_data", 32'(data), 32'(0));
        reset = 1'b0;
        cycles(2);

        // Directed: word 1101 sent as bits 1,0,1,1
        run_frame(4'b1101, 0, 0);
        // Both bits high on the second bit
        run_frame(4'b0110, 1, 1);
        // Dt drops after two bits
        run_frame(4'b0011, 2, 2);
`ifdef FE_RX_PARITY_EN
        run_frame(4'b1101, 0, 0);
        run_frame(4'b1101, 3, 0);
`endif

        // Reset while ack is high
        Dt = 1'b1;
        cycles(SYNC + 2);
        bit1 = 1'b1;
        wait_ack(1'b1, "pre_reset_ack");
        reset = 1'b1;
        #1;
        check("midrst_ack", 32'(ack), 32'(0));
        check("midrst_senack", 32'(senack), 32'(0));
        check("midrst_err", 32'(err), 32'(0));
        check("midrst_data", 32'(data), 32'(0));
        @(negedge clk);
        check("midrst_ack_hold", 32'(ack), 32'(0));
        Dt   = 1'b0;
        bit1 = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        model_word = '0;
        cycles(SYNC + 4);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            logic [WIDTH-1:0] w;
            int r;
            int kind;
            w    = WIDTH'($urandom);
            r    = int'($urandom_range(0, 5));
            kind = (r < 3) ? 0 : r - 2;
            if (kind > MAX_KIND)
                kind = 0;
            run_frame(w, kind, int'($urandom_range(0, NB - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
